// File: rtl/clef_pkg.sv
// clef_pkg: shared types and geometry for the treble-clef line fetcher.
//   fetch_state_t   - line-fetch sequencer states
//   CLEF_W/CLEF_H   - default glyph geometry in pixels
//   CLEF_ROM_DEPTH  - glyph ROM depth in bits (CLEF_W * CLEF_H)
//   ROM_LAT         - default glyph ROM read latency in cycles
//   clef_const_mul  - multiply by a constant using shifted accumulation
package clef_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } fetch_state_t;

    localparam int unsigned CLEF_W         = 40;
    localparam int unsigned CLEF_H         = 80;
    localparam int unsigned CLEF_ROM_DEPTH = 3200;
    localparam int unsigned ROM_LAT        = 2;

    // Sums a shifted copy of 'a' for every set bit of the constant 'k',
    // so the row base is built from adders only.
    function automatic logic [13:0] clef_const_mul(input logic [13:0] a,
                                                    input int unsigned k);
        logic [13:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 14; i++) begin
            if (((k >> i) & 32'd1) != 32'd0) begin
                acc = acc + (a << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/clef_line_buf.sv
// clef_line_buf: shadow/active double buffer for one glyph scanline.
//   clk, reset  - pixel clock, asynchronous active-high reset
//   wr_idx      - shadow column to write
//   wr_bit      - bit written to shadow[wr_idx]
//   wr_en       - shadow write strobe
//   shadow_clr  - zero the whole shadow buffer (wins over wr_en)
//   swap        - load the active buffer this cycle
//   swap_take   - on swap: 1 copies shadow, 0 clears active
//   active      - active scanline vector, bit c is glyph column c
module clef_line_buf #(
    parameter int unsigned W = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [$clog2(W)-1:0] wr_idx,
    input  logic                 wr_bit,
    input  logic                 wr_en,
    input  logic                 shadow_clr,
    input  logic                 swap,
    input  logic                 swap_take,
    output logic [W-1:0]         active
);

    logic [W-1:0] shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (shadow_clr) begin
                shadow <= '0;
            end else if (wr_en) begin
                shadow[wr_idx] <= wr_bit;
            end
            if (swap) begin
                active <= swap_take ? shadow : '0;
            end
        end
    end

endmodule

// File: rtl/clef_line_fetcher.sv
// clef_line_fetcher: fetches the next clef scanline from the glyph ROM during
// horizontal blanking and streams it as a gated pixel on the active line.
//   clk, reset  - pixel clock, asynchronous active-high reset
//   hcount      - current pixel column from VGA timing
//   vcount      - current line from VGA timing
//   enable      - output gate for clef_pixel (fetching is unaffected)
//   rom_addr    - glyph ROM address (registered)
//   rom_data    - glyph ROM bit, valid ROM_LAT cycles after its address
//   clef_pixel  - clef pixel for the previous cycle's hcount (registered)
//   fetch_busy  - FSM in S_ISSUE or S_DRAIN
//   fetch_err   - sticky overrun/retrigger flag, cleared by reset only
module clef_line_fetcher #(
    parameter int unsigned CLEF_X   = 16,
    parameter int unsigned CLEF_Y   = 40,
    parameter int unsigned CLEF_W   = clef_pkg::CLEF_W,
    parameter int unsigned CLEF_H   = clef_pkg::CLEF_H,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned ROM_LAT  = clef_pkg::ROM_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        enable,
    output logic [13:0] rom_addr,
    input  logic        rom_data,
    output logic        clef_pixel,
    output logic        fetch_busy,
    output logic        fetch_err
);

    import clef_pkg::*;

    localparam int unsigned CW   = $clog2(CLEF_W);
    localparam int unsigned PIPE = ROM_LAT * CW;

    localparam logic [9:0]    H_ACT_L    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_TOT_L    = 10'(V_TOTAL);
    localparam logic [9:0]    Y_LO_L     = 10'(CLEF_Y);
    localparam logic [9:0]    Y_HI_L     = 10'(CLEF_Y + CLEF_H);
    localparam logic [9:0]    X_LO_L     = 10'(CLEF_X);
    localparam logic [9:0]    X_HI_L     = 10'(CLEF_X + CLEF_W);
    localparam logic [CW-1:0] X_IDX_L    = CW'(CLEF_X);
    localparam logic [CW-1:0] COL_LAST   = CW'(CLEF_W - 1);
    localparam logic [7:0]    DRAIN_LAST = 8'(ROM_LAT - 1);

    fetch_state_t state, state_nxt;

    logic [CW-1:0]      col;
    logic [7:0]         drain_cnt;
    logic [ROM_LAT-1:0] pipe_vld;
    logic [PIPE-1:0]    pipe_idx;
    logic               shadow_valid;
    logic               hz_q;
    logic [CLEF_W-1:0]  active;

    logic [9:0]    vp1;
    logic [9:0]    vn;
    logic          row_in;
    logic [13:0]   row_base;
    logic          trigger;
    logic          swap;
    logic          busy_st;
    logic          issuing;
    logic          overrun;
    logic          flush;
    logic          cap_we;
    logic [CW-1:0] cap_idx;
    logic          in_win;
    logic [CW-1:0] pix_idx;

    // ---------------- line / trigger decode ----------------
    always_comb begin
        vp1      = vcount + 10'd1;
        vn       = (vp1 == V_TOT_L) ? '0 : vp1;
        row_in   = (vn >= Y_LO_L) && (vn < Y_HI_L);
        row_base = clef_const_mul(14'(vn - Y_LO_L), CLEF_W);
        trigger  = (hcount == H_ACT_L);
        // Swap only on the first cycle of a run of hcount == 0.
        swap     = (hcount == '0) && !hz_q;
        busy_st  = (state == S_ISSUE) || (state == S_DRAIN);
        issuing  = (state == S_ISSUE);
        overrun  = swap && busy_st;
        flush    = overrun || trigger;
        cap_we   = pipe_vld[ROM_LAT-1] && !flush;
        cap_idx  = pipe_idx[PIPE-1 -: CW];
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (overrun) begin
            state_nxt = S_IDLE;
        end else if (trigger) begin
            state_nxt = row_in ? S_ISSUE : S_DONE;
        end else begin
            case (state)
                S_ISSUE: if (col == COL_LAST)         state_nxt = S_DRAIN;
                S_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
                S_DONE:                               state_nxt = S_IDLE;
                default:                              state_nxt = state;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fetch_busy = busy_st;
    end

    // ---------------- fetch datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr     <= '0;
            col          <= '0;
            drain_cnt    <= '0;
            pipe_vld     <= '0;
            pipe_idx     <= '0;
            shadow_valid <= 1'b0;
            fetch_err    <= 1'b0;
            hz_q         <= 1'b0;
        end else begin
            hz_q <= (hcount == '0);

            // Column index travels with its valid bit so the write lands
            // ROM_LAT cycles after the address was issued.
            if (flush) begin
                pipe_vld <= '0;
            end else begin
                pipe_vld <= (pipe_vld << 1) | (ROM_LAT)'(issuing);
            end
            pipe_idx <= (pipe_idx << CW) | PIPE'(col);

            if (trigger) begin
                col <= '0;
                if (row_in) begin
                    rom_addr <= row_base;
                end
            end else if (issuing && !overrun && (col != COL_LAST)) begin
                col      <= col + 1'b1;
                rom_addr <= rom_addr + 14'd1;
            end

            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + 8'd1;
            end else begin
                drain_cnt <= '0;
            end

            if (overrun || swap) begin
                shadow_valid <= 1'b0;
            end else if (trigger) begin
                shadow_valid <= !row_in;
            end else if ((state == S_DRAIN) && (state_nxt == S_DONE)) begin
                shadow_valid <= 1'b1;
            end

            if (overrun || (trigger && busy_st)) begin
                fetch_err <= 1'b1;
            end
        end
    end

    // ---------------- line buffer ----------------
    clef_line_buf #(
        .W (CLEF_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .wr_idx     (cap_idx),
        .wr_bit     (rom_data),
        .wr_en      (cap_we),
        .shadow_clr (trigger && !row_in),
        .swap       (swap),
        .swap_take  (shadow_valid && !overrun),
        .active     (active)
    );

    // ---------------- pixel gate ----------------
    always_comb begin
        in_win  = (hcount >= X_LO_L) && (hcount < X_HI_L);
        pix_idx = in_win ? (hcount[CW-1:0] - X_IDX_L) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clef_pixel <= 1'b0;
        end else begin
            clef_pixel <= enable && in_win && active[pix_idx];
        end
    end

endmodule

// File: tb/tb_clef_line_fetcher.sv
// tb_clef_line_fetcher: directed, self-checking bench for clef_line_fetcher.
// A 2-cycle ROM model supplies glyph bits; expected pixels are queued as each
// hcount is driven and compared one cycle later against clef_pixel.
module tb_clef_line_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        enable;
    logic [13:0] rom_addr;
    logic        rom_data;
    logic        clef_pixel;
    logic        fetch_busy;
    logic        fetch_err;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic        pix_q[$];
    int unsigned addr_hold;
    logic        rom_d1;

    clef_line_fetcher #(
        .CLEF_X   (16),
        .CLEF_Y   (40),
        .CLEF_W   (40),
        .CLEF_H   (80),
        .H_ACTIVE (640),
        .V_TOTAL  (525),
        .ROM_LAT  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hcount     (hcount),
        .vcount     (vcount),
        .enable     (enable),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .clef_pixel (clef_pixel),
        .fetch_busy (fetch_busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    // Glyph content: row 0 has bit c = c odd, other rows a fixed hash.
    function automatic logic rom_fn(input int unsigned a);
        int unsigned h;
        if (a < 40) return a[0];
        h = a * 32'h9E3779B1;
        return h[13];
    endfunction

    function automatic logic [39:0] exp_row(input int unsigned r);
        logic [39:0] v;
        for (int unsigned c = 0; c < 40; c++) v[6'(c)] = rom_fn(r * 40 + c);
        return v;
    endfunction

    // Two-cycle-latency ROM.
    always @(posedge clk) begin
        rom_d1   <= rom_fn(32'(rom_addr));
        rom_data <= rom_d1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle (inputs just after the edge), sample at negedge and
    // retire the pixel expectation queued for the previous cycle.
    task automatic drive(input int unsigned h, input int unsigned v);
        logic e;
        @(posedge clk);
        #1;
        hcount = 10'(h);
        vcount = 10'(v);
        @(negedge clk);
        if (pix_q.size() > 0) begin
            e = pix_q.pop_front();
            chk($sformatf("pixel v=%0d h=%0d", v, h), 32'(clef_pixel), 32'(e));
        end
    endtask

    task automatic run_line(input int unsigned v, input logic [39:0] row,
                            input logic fetch, input int unsigned base,
                            input int unsigned last_h, input logic en,
                            input logic err);
        logic        p;
        int unsigned k;
        int unsigned ea;
        enable = en;
        for (int unsigned h = 0; h <= last_h; h++) begin
            drive(h, v);
            p = 1'b0;
            if (en && h >= 16 && h < 56) p = row[6'(h - 16)];
            pix_q.push_back(p);
            if (h == 1) chk($sformatf("busy_idle v=%0d", v), 32'(fetch_busy), 32'd0);
            if (h > 640 && h <= 683) begin
                k = h - 640;
                if (fetch) begin
                    ea = base + ((k <= 40) ? (k - 1) : 39);
                    chk($sformatf("addr v=%0d k=%0d", v, k), 32'(rom_addr), ea);
                    chk($sformatf("busy v=%0d k=%0d", v, k), 32'(fetch_busy), (k <= 42) ? 32'd1 : 32'd0);
                end else begin
                    chk($sformatf("addr_hold v=%0d k=%0d", v, k), 32'(rom_addr), addr_hold);
                    chk($sformatf("busy_none v=%0d k=%0d", v, k), 32'(fetch_busy), 32'd0);
                end
            end
            if (h == last_h) chk($sformatf("err v=%0d", v), 32'(fetch_err), 32'(err));
        end
        if (fetch && last_h >= 683) addr_hold = base + 39;
    endtask

    initial begin
        reset     = 1'b1;
        hcount    = 10'd700;
        vcount    = 10'd0;
        enable    = 1'b1;
        addr_hold = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr",  32'(rom_addr),   32'd0);
        chk("rst_pixel", 32'(clef_pixel), 32'd0);
        chk("rst_busy",  32'(fetch_busy), 32'd0);
        chk("rst_err",   32'(fetch_err),  32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single row, then last row and out-of-window lines.
        run_line(39,  '0,           1, 0,    799, 1, 0);
        run_line(40,  exp_row(0),   1, 40,   799, 1, 0);
        run_line(118, exp_row(1),   1, 3160, 799, 1, 0);
        run_line(119, exp_row(79),  0, 0,    799, 1, 0);
        run_line(120, '0,           0, 0,    799, 1, 0);

        // Frame wrap.
        run_line(524, '0,           0, 0,    799, 1, 0);
        run_line(0,   '0,           0, 0,    799, 1, 0);
        run_line(39,  '0,           1, 0,    799, 1, 0);
        run_line(40,  exp_row(0),   1, 40,   799, 1, 0);

        // Overrun: blanking cut short 20 cycles after the trigger.
        run_line(41,  exp_row(1),   1, 80,   659, 1, 0);
        run_line(42,  '0,           1, 120,  799, 1, 1);
        run_line(43,  exp_row(3),   1, 160,  799, 1, 1);

        // Enable gating over a fetch line and a window line.
        run_line(39,  exp_row(4),   1, 0,    799, 0, 1);
        run_line(40,  exp_row(0),   1, 40,   799, 0, 1);
        run_line(41,  exp_row(1),   1, 80,   799, 1, 1);

        // Asynchronous reset at column 10 of a fetch (rom_addr = 810).
        run_line(59,  exp_row(2),   1, 800,  651, 1, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_addr",  32'(rom_addr),   32'd0);
        chk("mid_rst_pixel", 32'(clef_pixel), 32'd0);
        chk("mid_rst_busy",  32'(fetch_busy), 32'd0);
        chk("mid_rst_err",   32'(fetch_err),  32'd0);
        pix_q.delete();
        addr_hold = 0;
        @(posedge clk);
        #1 hcount = 10'd700;
        #2 reset = 1'b0;

        run_line(70,  '0,           1, 1240, 799, 1, 0);
        run_line(71,  exp_row(31),  1, 1280, 799, 1, 0);
        drive(0, 72);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clef_line_fetcher.md
# clef_line_fetcher

Sequencer that owns the treble-clef glyph ROM and turns it into a VGA-rate pixel stream. During each horizontal blanking interval it reads the next scanline's 40 clef bits from the 2-cycle-latency ROM into a shadow line buffer. At the start of the active line it swaps the shadow buffer into an active buffer. During the active line it emits `clef_pixel` for the clef's screen window. It sits between the VGA timing generator and the display compositor, and it is the only master of the glyph ROM address port.

## Interface
- `CLEF_X`, 16: left screen column of the clef window.
- `CLEF_Y`, 40: top screen row of the clef window.
- `CLEF_W`, 40: glyph width in pixels.
- `CLEF_H`, 80: glyph height in pixels.
- `H_ACTIVE`, 640: active pixels per line.
- `V_TOTAL`, 525: total lines per frame, used for vcount wrap.
- `ROM_LAT`, 2: ROM read latency in cycles.
- `clk`  in  1  pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `hcount`  in  10  current pixel column from VGA timing.
- `vcount`  in  10  current line from VGA timing.
- `enable`  in  1  output gate; low forces `clef_pixel`=0. Fetching continues while low.
- `rom_addr`  out  14  glyph ROM address.
- `rom_data`  in  1  ROM bit; valid `ROM_LAT` cycles after its address.
- `clef_pixel`  out  1  clef pixel for the current (hcount, vcount), registered.
- `fetch_busy`  out  1  high while the FSM is in S_ISSUE or S_DRAIN.
- `fetch_err`  out  1  sticky; set on any overrun; cleared only by `reset`.

## Operation
- **Fetch trigger:** when `hcount == H_ACTIVE`, the next line is vn = (vcount+1 == V_TOTAL) ? 0 : vcount+1.
  - If CLEF_Y ≤ vn < CLEF_Y+CLEF_H: row r = vn−CLEF_Y; FSM goes S_IDLE→S_ISSUE.
  - Otherwise: shadow buffer is zeroed, `shadow_valid` is set, FSM goes directly to S_DONE.
- **S_ISSUE:** for CLEF_W cycles, column counter c = 0..CLEF_W−1; `rom_addr` = r·CLEF_W + c.
  - The base r·CLEF_W is formed by accumulation, with no multiplier.
  - Maximum address is 3199. Unsigned 14-bit arithmetic, no overflow.
- **S_DRAIN:** ROM_LAT cycles; `rom_addr` holds its last value.
- **Data capture:** each `rom_data` bit is written to shadow[c_d], where c_d is c delayed by ROM_LAT through a valid/index shift pipe. Capture runs through S_ISSUE and S_DRAIN.
- **S_DONE:** entered after the last capture; `shadow_valid` = 1; FSM returns to S_IDLE on the next cycle.
- **Swap, first cycle with `hcount == 0`:**
  - active ← `shadow_valid` ? shadow : 0.
  - `shadow_valid` ← 0.
- **Overrun at swap:** if the FSM is in S_ISSUE or S_DRAIN at the swap cycle:
  - active ← 0;
  - FSM aborts to S_IDLE;
  - `fetch_err` ← 1.
- **Retrigger:** a fetch trigger while the FSM is busy restarts the fetch for the new row and sets `fetch_err`.
- **Pixel output:** `clef_pixel` ← `enable` && CLEF_X ≤ hcount < CLEF_X+CLEF_W && active[hcount−CLEF_X].
  - The index is a 6-bit subtraction, evaluated only inside the window.

## Timing
- **Reset values:** `rom_addr`=0, `clef_pixel`=0, `fetch_busy`=0, `fetch_err`=0; FSM S_IDLE; both buffers 0; `shadow_valid`=0; delay pipe invalid.
- **Fetch duration:** trigger → S_DONE is 1 + CLEF_W + ROM_LAT = 43 cycles. This is well inside the 160-cycle blanking interval.
- **Address/data alignment:** address issued in cycle t is captured from `rom_data` in cycle t+ROM_LAT.
- **Pixel latency:** `clef_pixel` lags `hcount` by 1 cycle. The compositor compensates.
- **Mid-fetch reset:** the fetch is abandoned immediately and the active buffer is cleared. The first line after reset shows no clef.
- **First row:** row 0 of the glyph is fetched during blanking of line CLEF_Y−1 and displayed on line CLEF_Y.
- **Frame wrap:** vcount = V_TOTAL−1 → vn = 0. This is outside the window unless CLEF_Y = 0, in which case row 0 is fetched.

## Structure
- **Package `clef_pkg`:**
  - `typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} fetch_state_t`;
  - geometry defaults (CLEF_W, CLEF_H, CLEF_ROM_DEPTH = 3200);
  - ROM_LAT.
- **Sub-module `clef_line_buf`:** the shadow/active double buffer.
  - Inputs: write port (index, bit, we), swap strobe, shadow-clear.
  - Output: 40-bit active vector.
- The FSM, counters and pixel gate stay in the top level.

## Test plan
- **Single row:** ROM model with row 0 = 0xAA_AAAA_AAAA (bit c = c odd). Drive vcount = 39, hcount = 640 → `rom_addr` steps 0..39 over 40 cycles and `fetch_busy` lasts 42 cycles. On line 40, `clef_pixel` = 1 at hcount 17, 19, …, 55 (one cycle later) and 0 at hcount 16, 15 and 56.
- **Last row / out of window:** vcount = 118 → addresses 3160..3199. Line 120 produces no ROM access (`rom_addr` unchanged) and `clef_pixel` = 0 all line.
- **Frame wrap:** vcount = 524 at trigger → no fetch; line 0 output all 0. Then vcount = 39 fetches correctly.
- **Overrun:** force hcount from 640 to 0 after 20 cycles → `fetch_err` = 1, FSM in S_IDLE, `clef_pixel` = 0 for the whole line. The next normal line displays correctly while `fetch_err` stays 1.
- **Enable gating:** `enable` = 0 across a window line → `clef_pixel` = 0, while `rom_addr` still sequences 0..39.
- **Async reset mid-fetch:** assert `reset` at c = 10 → all outputs 0 in the same cycle. Release; the next trigger fetches row r from address r·40.
